aes128_inv_cipher_seq: RTL and testbench

//  Iterative AES inverse cipher core for the decryption path; the counterpart of the encryption datapath.

---
 rtl/aes128_inv_cipher_seq.sv | 139 +++++++++++++
 tb/tb_aes128_inv_cipher_seq.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_inv_cipher_seq.sv
// aes128_inv_cipher_seq: iterative AES inverse cipher with byte-serial external inverse S-box and external round keys
module aes128_inv_cipher_seq #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic [3:0]   rk_idx,
  input  logic [127:0] rk_data,
  output logic [7:0]   sbox_addr,
  input  logic [7:0]   sbox_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);
  typedef enum logic [2:0] {IDLE, SHIFT, SUB, ADDKEY, MIX, DONE} state_t;

  state_t       state, state_n;
  logic [127:0] st, st_n;
  logic [3:0]   rnd, rnd_n, bcnt, bcnt_n;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul9(input logic [7:0] b);
    logic [7:0] x8;
    x8 = xtime(xtime(xtime(b)));
    return x8 ^ b;
  endfunction

  function automatic logic [7:0] mulb(input logic [7:0] b);
    logic [7:0] x2, x8;
    x2 = xtime(b);
    x8 = xtime(xtime(x2));
    return x8 ^ x2 ^ b;
  endfunction

  function automatic logic [7:0] muld(input logic [7:0] b);
    logic [7:0] x4, x8;
    x4 = xtime(xtime(b));
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic logic [7:0] mule(input logic [7:0] b);
    logic [7:0] x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

  // byte (r,c) sits at [127-8*(4c+r) -: 8]; row r rotates right by r
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {mule(a0) ^ mulb(a1) ^ muld(a2) ^ mul9(a3),
                           mul9(a0) ^ mule(a1) ^ mulb(a2) ^ muld(a3),
                           muld(a0) ^ mul9(a1) ^ mule(a2) ^ mulb(a3),
                           mulb(a0) ^ muld(a1) ^ mul9(a2) ^ mule(a3)};
    end
    return o;
  endfunction

  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign out_data  = st;
  assign rk_idx    = (state == IDLE) ? 4'(NR) : rnd;
  assign sbox_addr = st[{~bcnt, 3'b000} +: 8];

  // next-state and datapath update for each phase of a round
  always_comb begin
    state_n = state;
    st_n    = st;
    rnd_n   = rnd;
    bcnt_n  = bcnt;
    case (state)
      IDLE: if (in_valid) begin
        st_n    = in_data ^ rk_data;
        rnd_n   = 4'(NR - 1);
        state_n = SHIFT;
      end
      SHIFT: begin
        st_n    = inv_shift_rows(st);
        bcnt_n  = '0;
        state_n = SUB;
      end
      SUB: begin
        st_n[{~bcnt, 3'b000} +: 8] = sbox_data;
        bcnt_n  = bcnt + 4'd1;
        state_n = (bcnt == 4'd15) ? ADDKEY : SUB;
      end
      ADDKEY: begin
        st_n    = st ^ rk_data;
        state_n = (rnd == '0) ? DONE : MIX;
      end
      MIX: begin
        st_n    = inv_mix_columns(st);
        rnd_n   = rnd - 4'd1;
        state_n = SHIFT;
      end
      DONE: state_n = out_ready ? IDLE : DONE;
      default: state_n = IDLE;
    endcase
  end

  // state registers; reset overrides any same-cycle handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      st    <= '0;
      rnd   <= '0;
      bcnt  <= '0;
    end else begin
      state <= state_n;
      st    <= st_n;
      rnd   <= rnd_n;
      bcnt  <= bcnt_n;
    end
  end
endmodule

// File: tb/tb_aes128_inv_cipher_seq.sv
// tb_aes128_inv_cipher_seq: checks the inverse cipher core against FIPS-197 C.1 and a forward-cipher model
module tb_aes128_inv_cipher_seq;
  logic         clk, rst, in_valid, in_ready, out_valid, out_ready;
  logic [127:0] in_data, rk_data, out_data;
  logic [3:0]   rk_idx;
  logic [7:0]   sbox_addr, sbox_data;

  logic [7:0]   sbox [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] rk [16];
  int           checks = 0, failures = 0, cyc = 0;

  typedef struct {
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;
  vec_t tbl [4];

  aes128_inv_cipher_seq #(.NR(10)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .rk_idx(rk_idx), .rk_data(rk_data), .sbox_addr(sbox_addr), .sbox_data(sbox_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  assign sbox_data = inv_sbox[sbox_addr];
  assign rk_data   = rk[rk_idx];

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p ^= a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  task automatic build_tables(input logic [127:0] key);
    logic [7:0]  inv, s, rc;
    logic [31:0] w [44];
    logic [31:0] t;
    for (int x = 0; x < 256; x++) begin
      inv = 0;
      for (int y = 1; y < 256; y++)
        if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      sbox[x] = s;
      inv_sbox[s] = 8'(x);
    end
    rc = 8'h01;
    for (int i = 0; i < 44; i++) begin
      if (i < 4) w[i] = key[127-32*i -: 32];
      else begin
        t = w[i-1];
        if (i % 4 == 0) begin
          t = {t[23:0], t[31:24]};
          t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
          rc = gf_mul(rc, 8'h02);
        end
        w[i] = w[i-4] ^ t;
      end
    end
    for (int r = 0; r < 16; r++) rk[r] = (r < 11) ? {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]} : '0;
  endtask

  // textbook forward cipher on a 16-byte array, used to make ciphertexts for random plaintexts
  function automatic logic [127:0] model_encrypt(input logic [127:0] pt);
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   coef [4];
    logic [127:0] o, k;
    coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    k = rk[0];
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[4*(((i/4) + (i%4)) % 4) + i%4]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++) begin
          s[4*c+row] = 0;
          for (int j = 0; j < 4; j++)
            s[4*c+row] ^= (r < 10) ? gf_mul(coef[(j-row+4)%4], t[4*c+j]) : ((j == row) ? t[4*c+j] : 8'h00);
        end
      k = rk[r];
      for (int i = 0; i < 16; i++) s[i] ^= k[127-8*i -: 8];
    end
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
    return o;
  endfunction

  // one transaction: accept, measure latency, optionally hold in DONE, then hand shake out
  task automatic do_block(input logic [127:0] ct, input logic [127:0] pt, input int hold, input logic [127:0] next_ct);
    logic [3:0]   q[$];
    logic [127:0] held;
    int           n, bad;
    bit           ok;
    in_data = ct;
    in_valid = 1;
    n = 0;
    while (!in_ready && n < 500) begin tick; n++; end
    check("accept_ready", 128'(in_ready), 128'(1));
    q.push_back(rk_idx);
    tick;
    n = 0;
    while (!out_valid && n < 400) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      if (q[$] != rk_idx) q.push_back(rk_idx);
      tick;
      n++;
    end
    in_valid = 0;
    check("latency", 128'(n), 128'(189));
    check("plaintext", out_data, pt);
    ok = q.size() == 11;
    foreach (q[k]) if (q[k] != 4'(10 - k)) ok = 0;
    check("rk_idx_seq", 128'(ok), 128'(1));
    if (hold > 0) begin
      held = out_data;
      bad = 0;
      in_valid = 1;
      in_data = next_ct;
      for (int i = 0; i < hold; i++) begin
        tick;
        if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
      end
      check("hold_stable", 128'(bad), 128'(0));
    end
    out_ready = 1;
    tick;
    out_ready = 0;
    check("post_hs_out_valid", 128'(out_valid), 128'(0));
    check("post_hs_in_ready", 128'(in_ready), 128'(1));
  endtask

  initial begin
    logic [127:0] c1_ct, c1_pt;
    int nacc, nout, bad;
    int acc [3];
    c1_ct = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    c1_pt = 128'h00112233445566778899aabbccddeeff;
    build_tables(128'h000102030405060708090a0b0c0d0e0f);
    tbl[0] = '{c1_ct, c1_pt};
    for (int i = 1; i < 4; i++) begin
      tbl[i].pt = (i == 3) ? 128'h0 : {$urandom, $urandom, $urandom, $urandom};
      tbl[i].ct = model_encrypt(tbl[i].pt);
    end

    rst = 1;
    in_valid = 1;
    in_data = {$urandom, $urandom, $urandom, $urandom};
    out_ready = 0;
    tick;
    tick;
    check("rst_in_ready", 128'(in_ready), 128'(1));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'h0);
    check("rst_rk_idx", 128'(rk_idx), 128'(10));
    check("rst_sbox_addr", 128'(sbox_addr), 128'(0));
    rst = 0;
    in_valid = 0;
    tick;
    check("rst_no_capture", out_data, 128'h0);

    for (int i = 0; i < 4; i++) do_block(tbl[i].ct, tbl[i].pt, 0, '0);

    do_block(c1_ct, c1_pt, 30, tbl[1].ct);
    do_block(tbl[1].ct, tbl[1].pt, 0, '0);

    in_data = c1_ct;
    in_valid = 1;
    tick;
    in_valid = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin tick; if (out_valid) bad++; end
    rst = 1;
    tick;
    rst = 0;
    check("midrst_in_ready", 128'(in_ready), 128'(1));
    check("midrst_out_data", out_data, 128'h0);
    for (int i = 0; i < 200; i++) begin tick; if (out_valid) bad++; end
    check("midrst_no_out_valid", 128'(bad), 128'(0));
    do_block(c1_ct, c1_pt, 0, '0);

    out_ready = 1;
    in_valid = 1;
    in_data = tbl[0].ct;
    nacc = 0;
    nout = 0;
    for (int n = 0; n < 700 && nout < 3; n++) begin
      if (in_valid && in_ready && nacc < 3) begin acc[nacc] = cyc; nacc++; end
      if (out_valid) begin check("b2b_data", out_data, tbl[nout].pt); nout++; end
      tick;
      if (nacc < 3) in_data = tbl[nacc].ct;
    end
    check("b2b_count", 128'(nout), 128'(3));
    check("b2b_space1", 128'(acc[1] - acc[0]), 128'(191));
    check("b2b_space2", 128'(acc[2] - acc[1]), 128'(191));
    in_valid = 0;
    out_ready = 0;
    rst = 1;
    tick;
    rst = 0;
    tick;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
